// File: rtl/ysyx_22050039_seq_ctrl_if.sv
// Handshake and enable bundle between the sequencing controller and the RV64 datapath.
// master = controller side, slave = datapath side.
interface ysyx_22050039_seq_ctrl_if;
  logic ifu_req;
  logic ifu_ack;
  logic inst_latch;
  logic dec_load;
  logic dec_store;
  logic dec_mdu;
  logic dec_wreg;
  logic dec_wpc;
  logic dec_ebreak;
  logic dec_invalid;
  logic mdu_start;
  logic mdu_done;
  logic lsu_req;
  logic lsu_we;
  logic lsu_ack;
  logic reg_total_wen;
  logic pc_en;
  logic pc_sel;
  logic retire;

  modport master (
    output ifu_req, inst_latch, mdu_start, lsu_req, lsu_we,
           reg_total_wen, pc_en, pc_sel, retire,
    input  ifu_ack, mdu_done, lsu_ack,
           dec_load, dec_store, dec_mdu, dec_wreg, dec_wpc, dec_ebreak, dec_invalid
  );

  modport slave (
    input  ifu_req, inst_latch, mdu_start, lsu_req, lsu_we,
           reg_total_wen, pc_en, pc_sel, retire,
    output ifu_ack, mdu_done, lsu_ack,
           dec_load, dec_store, dec_mdu, dec_wreg, dec_wpc, dec_ebreak, dec_invalid
  );
endinterface

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with per-wait watchdog and
// sticky HALT/ERR terminal states.
module ysyx_22050039_seq_ctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned TO_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22050039_seq_ctrl_if.master bus,
  output logic [XLEN-1:0]          instret,
  output logic                     halt,
  output logic                     err,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Last count before the limit: a wait cycle seen here without an ack times out.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          cur, nxt;
  logic [TO_W-1:0] wdog, wdog_d;
  logic            mdu_wait, mdu_wait_d;
  logic            lat_load, lat_store, lat_mdu, lat_wreg, lat_wpc;
  state_t          exec_exit;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= FETCH;
      wdog      <= '0;
      mdu_wait  <= 1'b0;
      lat_load  <= 1'b0;
      lat_store <= 1'b0;
      lat_mdu   <= 1'b0;
      lat_wreg  <= 1'b0;
      lat_wpc   <= 1'b0;
      instret   <= '0;
    end else begin
      cur      <= nxt;
      wdog     <= wdog_d;
      mdu_wait <= mdu_wait_d;
      if (cur == DECODE) begin
        lat_load  <= bus.dec_load;
        lat_store <= bus.dec_store;
        lat_mdu   <= bus.dec_mdu;
        lat_wreg  <= bus.dec_wreg;
        lat_wpc   <= bus.dec_wpc;
      end
      if (cur == WB) begin
        instret <= instret + XLEN'(1);
      end
    end
  end

  always_comb begin
    nxt               = cur;
    wdog_d            = wdog;
    mdu_wait_d        = mdu_wait;
    exec_exit         = (lat_load || lat_store) ? MEM : WB;
    bus.ifu_req       = 1'b0;
    bus.inst_latch    = 1'b0;
    bus.mdu_start     = 1'b0;
    bus.lsu_req       = 1'b0;
    bus.lsu_we        = 1'b0;
    bus.reg_total_wen = 1'b0;
    bus.pc_en         = 1'b0;
    bus.pc_sel        = 1'b0;
    bus.retire        = 1'b0;
    halt              = 1'b0;
    err               = 1'b0;

    case (cur)
      FETCH: begin
        bus.ifu_req = 1'b1;
        if (bus.ifu_ack) begin
          bus.inst_latch = 1'b1;
          nxt            = DECODE;
        end else if (wdog == WD_LAST) begin
          nxt = ERR;
        end else begin
          wdog_d = wdog + TO_W'(1);
        end
      end
      DECODE: begin
        if (bus.dec_invalid)     nxt = ERR;
        else if (bus.dec_ebreak) nxt = HALT;
        else                     nxt = EXEC;
      end
      EXEC: begin
        if (!lat_mdu) begin
          nxt = exec_exit;
        end else if (!mdu_wait) begin
          // Start cycle: mdu_done is not looked at; the wait phase begins with a fresh watchdog.
          bus.mdu_start = 1'b1;
          mdu_wait_d    = 1'b1;
          wdog_d        = '0;
        end else if (bus.mdu_done) begin
          nxt = exec_exit;
        end else if (wdog == WD_LAST) begin
          nxt = ERR;
        end else begin
          wdog_d = wdog + TO_W'(1);
        end
      end
      MEM: begin
        bus.lsu_req = 1'b1;
        bus.lsu_we  = lat_store;
        if (bus.lsu_ack) begin
          nxt = WB;
        end else if (wdog == WD_LAST) begin
          nxt = ERR;
        end else begin
          wdog_d = wdog + TO_W'(1);
        end
      end
      WB: begin
        bus.reg_total_wen = lat_wreg;
        bus.pc_en         = 1'b1;
        bus.pc_sel        = lat_wpc;
        bus.retire        = 1'b1;
        nxt               = FETCH;
      end
      HALT:    halt = 1'b1;
      ERR:     err  = 1'b1;
      default: nxt  = ERR;
    endcase

    // Any state change starts the next wait phase with a cleared watchdog.
    if (nxt != cur) begin
      wdog_d     = '0;
      mdu_wait_d = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_ysyx_22050039_seq_ctrl.sv
// Directed bench for the sequencing controller: cycle-by-cycle output vectors
// for ALU, load/store, jump, MDU, ebreak, invalid, watchdog and reset cases.
module tb_ysyx_22050039_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] instret;
  logic        halt;
  logic        err;
  logic [2:0]  state;

  ysyx_22050039_seq_ctrl_if bus ();

  ysyx_22050039_seq_ctrl #(
    .XLEN (64),
    .TO_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .instret (instret),
    .halt    (halt),
    .err     (err),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output flag vector bits: ifu_req inst_latch mdu_start lsu_req lsu_we wen pc_en pc_sel retire halt err
  localparam logic [10:0] O_IFU  = 11'h400;
  localparam logic [10:0] O_LAT  = 11'h200;
  localparam logic [10:0] O_MST  = 11'h100;
  localparam logic [10:0] O_LSU  = 11'h080;
  localparam logic [10:0] O_WE   = 11'h040;
  localparam logic [10:0] O_WEN  = 11'h020;
  localparam logic [10:0] O_PCEN = 11'h010;
  localparam logic [10:0] O_PSEL = 11'h008;
  localparam logic [10:0] O_RET  = 11'h004;
  localparam logic [10:0] O_HALT = 11'h002;
  localparam logic [10:0] O_ERR  = 11'h001;

  // Decoder flag vector bits: load store mdu wreg wpc ebreak invalid
  localparam logic [6:0] D_LOAD  = 7'h40;
  localparam logic [6:0] D_STORE = 7'h20;
  localparam logic [6:0] D_MDU   = 7'h10;
  localparam logic [6:0] D_WREG  = 7'h08;
  localparam logic [6:0] D_WPC   = 7'h04;
  localparam logic [6:0] D_EBRK  = 7'h02;
  localparam logic [6:0] D_INV   = 7'h01;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [63:0] exp_ret = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [13:0] obs();
    return {state, bus.ifu_req, bus.inst_latch, bus.mdu_start, bus.lsu_req, bus.lsu_we,
            bus.reg_total_wen, bus.pc_en, bus.pc_sel, bus.retire, halt, err};
  endfunction

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [10:0] fl);
    #1;
    check(tag, 64'(obs()), 64'({st, fl}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [6:0] d);
    {bus.dec_load, bus.dec_store, bus.dec_mdu, bus.dec_wreg,
     bus.dec_wpc, bus.dec_ebreak, bus.dec_invalid} = d;
  endtask

  task automatic clear_inputs();
    bus.ifu_ack  = 1'b0;
    bus.mdu_done = 1'b0;
    bus.lsu_ack  = 1'b0;
    set_dec('0);
  endtask

  // Leaves the bench in the first cycle with rst low and the DUT in FETCH.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    tick();
    expect_cyc({tag, "_rst"}, 3'd0, O_IFU);
    check({tag, "_rst_instret"}, instret, 64'd0);
    exp_ret = '0;
    rst = 1'b0;
  endtask

  // Zero-wait fetch plus DECODE; returns in the cycle after DECODE, unchecked.
  task automatic fetch_decode(input string tag, input logic [6:0] d);
    bus.ifu_ack = 1'b1;
    set_dec(d);
    expect_cyc({tag, "_fetch"}, 3'd0, O_IFU | O_LAT);
    tick();
    expect_cyc({tag, "_decode"}, 3'd1, '0);
    tick();
    bus.ifu_ack = 1'b0;
    set_dec('0);
  endtask

  task automatic wb_check(input string tag, input logic [10:0] fl);
    expect_cyc({tag, "_wb"}, 3'd4, fl);
    check({tag, "_wb_instret"}, instret, exp_ret);
    exp_ret = exp_ret + 64'd1;
    tick();
    expect_cyc({tag, "_next_fetch"}, 3'd0, O_IFU);
    check({tag, "_instret"}, instret, exp_ret);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    do_reset("init");

    // ADD, ack held high through DECODE to confirm inst_latch is FETCH-only
    fetch_decode("add", D_WREG);
    expect_cyc("add_exec", 3'd2, '0);
    tick();
    wb_check("add", O_WEN | O_PCEN | O_RET);

    // Load, lsu_ack on the fourth MEM cycle
    fetch_decode("ld", D_LOAD | D_WREG);
    expect_cyc("ld_exec", 3'd2, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.lsu_ack = (i == 3);
      expect_cyc($sformatf("ld_mem%0d", i), 3'd3, O_LSU);
      tick();
    end
    bus.lsu_ack = 1'b0;
    wb_check("ld", O_WEN | O_PCEN | O_RET);

    for (int i = 0; i < 2; i++) begin
      expect_cyc($sformatf("fetch_wait%0d", i), 3'd0, O_IFU);
      tick();
    end

    // JAL then SD
    fetch_decode("jal", D_WPC | D_WREG);
    expect_cyc("jal_exec", 3'd2, '0);
    tick();
    wb_check("jal", O_WEN | O_PCEN | O_PSEL | O_RET);
    fetch_decode("sd", D_STORE);
    expect_cyc("sd_exec", 3'd2, '0);
    tick();
    bus.lsu_ack = 1'b1;
    expect_cyc("sd_mem", 3'd3, O_LSU | O_WE);
    tick();
    bus.lsu_ack = 1'b0;
    wb_check("sd", O_PCEN | O_RET);

    // DIVW: done held on the start cycle, then arrives 5 cycles after start
    fetch_decode("div", D_MDU | D_WREG);
    bus.mdu_done = 1'b1;
    expect_cyc("div_start", 3'd2, O_MST);
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.mdu_done = (i == 5);
      expect_cyc($sformatf("div_wait%0d", i), 3'd2, '0);
      tick();
    end
    bus.mdu_done = 1'b0;
    wb_check("div", O_WEN | O_PCEN | O_RET);

    // MDU wait timeout
    fetch_decode("mdu_to", D_MDU);
    expect_cyc("mdu_to_start", 3'd2, O_MST);
    tick();
    for (int i = 1; i <= 15; i++) begin
      expect_cyc($sformatf("mdu_to_wait%0d", i), 3'd2, '0);
      tick();
    end
    expect_cyc("mdu_to_err", 3'd6, O_ERR);
    do_reset("mdu_to");

    // MEM wait timeout
    fetch_decode("mem_to", D_LOAD);
    expect_cyc("mem_to_exec", 3'd2, '0);
    tick();
    for (int i = 1; i <= 15; i++) begin
      expect_cyc($sformatf("mem_to_wait%0d", i), 3'd3, O_LSU);
      tick();
    end
    expect_cyc("mem_to_err", 3'd6, O_ERR);
    do_reset("mem_to");

    // ebreak: sticky HALT, every input ignored
    fetch_decode("ebrk", D_EBRK);
    bus.ifu_ack  = 1'b1;
    bus.lsu_ack  = 1'b1;
    bus.mdu_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_cyc($sformatf("halt%0d", i), 3'd5, O_HALT);
      tick();
    end
    do_reset("ebrk");

    // invalid wins over ebreak
    fetch_decode("inv", D_INV | D_EBRK);
    expect_cyc("inv_err0", 3'd6, O_ERR);
    tick();
    bus.ifu_ack = 1'b1;
    expect_cyc("inv_err1", 3'd6, O_ERR);
    do_reset("inv");

    // Fetch watchdog: 15 waiting cycles without ack
    for (int i = 1; i <= 15; i++) begin
      expect_cyc($sformatf("if_to_wait%0d", i), 3'd0, O_IFU);
      tick();
    end
    expect_cyc("if_to_err", 3'd6, O_ERR);
    do_reset("if_to");

    // Ack on the 15th waiting cycle wins over the timeout
    for (int i = 1; i <= 14; i++) begin
      expect_cyc($sformatf("if_ok_wait%0d", i), 3'd0, O_IFU);
      tick();
    end
    bus.ifu_ack = 1'b1;
    expect_cyc("if_ok_ack", 3'd0, O_IFU | O_LAT);
    tick();
    bus.ifu_ack = 1'b0;
    expect_cyc("if_ok_decode", 3'd1, '0);
    tick();
    expect_cyc("if_ok_exec", 3'd2, '0);
    tick();
    wb_check("if_ok", O_PCEN | O_RET);

    // Reset in the middle of MEM, then a stale lsu_ack in FETCH
    fetch_decode("rmem", D_STORE);
    expect_cyc("rmem_exec", 3'd2, '0);
    tick();
    expect_cyc("rmem_mem0", 3'd3, O_LSU | O_WE);
    tick();
    rst = 1'b1;
    expect_cyc("rmem_mem1", 3'd3, O_LSU | O_WE);
    tick();
    rst = 1'b0;
    bus.lsu_ack = 1'b1;
    expect_cyc("rmem_after_rst", 3'd0, O_IFU);
    check("rmem_instret", instret, 64'd0);
    tick();
    expect_cyc("rmem_stale_ack", 3'd0, O_IFU);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
